// File: rtl/tff_bank_ctrl_if.sv
// Control/feedback bundle between the TFF bank controller and its environment.
// The slave modport is the controller side; the master side drives requests and bank feedback.
interface tff_bank_ctrl_if #(
  parameter int WIDTH = 4
);
  logic             start;
  logic             stop;
  logic             up_dn;
  logic [WIDTH-1:0] limit;
  logic [WIDTH-1:0] q_fb;
  logic [WIDTH-1:0] t_out;
  logic             busy;
  logic             done;
  logic             tc;

  modport master (
    output start, stop, up_dn, limit, q_fb,
    input  t_out, busy, done, tc
  );

  modport slave (
    input  start, stop, up_dn, limit, q_fb,
    output t_out, busy, done, tc
  );
endinterface

// File: rtl/tff_bank_ctrl.sv
// Sequencer that drives the T inputs of an external flip-flop bank to clear it and count to a limit.
// Define TFFC_WRAP_EN to make the count wrap back to its start value at the limit instead of finishing.
module tff_bank_ctrl #(
  parameter int WIDTH = 4
) (
  input  logic           clk,
  input  logic           reset,
  tff_bank_ctrl_if.slave bus
);

  typedef enum logic [2:0] {
    IDLE,
    CLEAR,
    RUN,
    PAUSE,
    DONE
  } state_t;

  state_t           state_q, state_d;
  logic             dir_q, dir_d;
  logic [WIDTH-1:0] lim_q, lim_d;
  logic             tc_q, tc_d;
  logic [WIDTH-1:0] countT;
  logic [WIDTH-1:0] tOut;
  logic             carry;
  logic             stopReq;
  logic             startReq;
  logic             atLimit;

  assign stopReq  = bus.stop;
  assign startReq = bus.start & ~bus.stop;
  assign atLimit  = (bus.q_fb == lim_q);

  // Ripple-carry toggle pattern: bit i flips when all lower bits are 1 (up) or 0 (down).
  always_comb begin
    countT = '0;
    carry  = 1'b1;
    for (int i = 0; i < WIDTH; i++) begin
      countT[i] = carry;
      carry     = carry & (dir_q ? bus.q_fb[i] : ~bus.q_fb[i]);
    end
  end

  always_comb begin
    state_d = state_q;
    dir_d   = dir_q;
    lim_d   = lim_q;
    tc_d    = 1'b0;
    tOut    = '0;
    unique case (state_q)
      IDLE: begin
        if (startReq) begin
          state_d = CLEAR;
          dir_d   = bus.up_dn;
          lim_d   = bus.limit;
        end
      end
      CLEAR: begin
        tOut    = dir_q ? bus.q_fb : ~bus.q_fb;
        state_d = RUN;
      end
      RUN: begin
        if (stopReq) begin
          state_d = PAUSE;
        end else if (atLimit) begin
          tc_d = 1'b1;
`ifdef TFFC_WRAP_EN
          tOut = dir_q ? bus.q_fb : ~bus.q_fb;
`else
          state_d = DONE;
`endif
        end else begin
          tOut = countT;
        end
      end
      PAUSE: begin
        if (stopReq) begin
          state_d = IDLE;
        end else if (startReq) begin
          state_d = RUN;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      dir_q   <= 1'b1;
      lim_q   <= '0;
      tc_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      dir_q   <= dir_d;
      lim_q   <= lim_d;
      tc_q    <= tc_d;
    end
  end

  assign bus.t_out = tOut;
  assign bus.busy  = (state_q != IDLE);
  assign bus.done  = (state_q == DONE);
  assign bus.tc    = tc_q;

endmodule

// File: tb/tb_tff_bank_ctrl.sv
// Self-checking bench for tff_bank_ctrl: models the T flip-flop bank, scoreboards each terminal-count pulse.
// Builds with or without TFFC_WRAP_EN; the wrap build runs the wrapping scenario only.
module tb_tff_bank_ctrl;

  localparam int W = 4;

  typedef struct {
    int expQ;
    int expDone;
    int expLat;
  } sbEntry_t;

  logic         clk = 1'b0;
  logic         reset;
  logic [W-1:0] bankQ;
  logic         bankLoad;
  logic [W-1:0] bankLoadVal;
  int           passCnt = 0;
  int           checkCnt = 0;
  sbEntry_t     sbQ[$];
  int           busyCnt = 0;
  logic         prevBusy = 1'b0;

  tff_bank_ctrl_if #(.WIDTH(W)) ifc ();

  tff_bank_ctrl #(.WIDTH(W)) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (ifc.slave)
  );

  always #5 clk = ~clk;

  // External T flip-flop bank on the same clock; the load path stands in for its own reset.
  always @(posedge clk) begin
    if (bankLoad) bankQ <= bankLoadVal;
    else          bankQ <= bankQ ^ ifc.t_out;
  end

  assign ifc.q_fb = bankQ;

  task automatic checkOutput(input string name, input int act, input int exp);
    checkCnt++;
    if (act == exp) passCnt++;
    else $display("[TB] FAIL %s: got %0d, expected %0d", name, act, exp);
  endtask

  // Monitor: counts busy cycles from the launch and scores every tc pulse against the queue.
  always @(negedge clk) begin
    sbEntry_t e;
    if (ifc.busy) busyCnt = prevBusy ? busyCnt + 1 : 0;
    prevBusy = ifc.busy;
    if (ifc.tc) begin
      if (sbQ.size() == 0) begin
        checkOutput("unexpected_tc", 1, 0);
      end else begin
        e = sbQ.pop_front();
        checkOutput("tc_q_value", int'(bankQ), e.expQ);
        checkOutput("tc_done", int'(ifc.done), e.expDone);
        if (e.expLat >= 0) checkOutput("tc_latency", busyCnt, e.expLat);
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic pushExp(input int q, input int dn, input int lat);
    sbEntry_t e;
    e.expQ = q;
    e.expDone = dn;
    e.expLat = lat;
    sbQ.push_back(e);
  endtask

  // Reference: an up run needs lim steps from 0, a down run 15-lim steps from 15; plus CLEAR and the match cycle.
  function automatic int runLatency(input int dir, input int lim);
    return (dir != 0) ? lim + 2 : ((1 << W) - 1 - lim) + 2;
  endfunction

  task automatic applyStimulus(input int dir, input int lim, input bit push, input int lat);
    ifc.up_dn = dir[0];
    ifc.limit = lim[W-1:0];
    ifc.start = 1'b1;
    if (push) pushExp(lim, 1, lat);
    tick();
    ifc.start = 1'b0;
    ifc.up_dn = 1'($urandom);
    ifc.limit = W'($urandom);
  endtask

  task automatic loadBank(input int val);
    bankLoad = 1'b1;
    bankLoadVal = val[W-1:0];
    tick();
    bankLoad = 1'b0;
  endtask

  task automatic waitIdle();
    int n = 0;
    while (ifc.busy && n < 60) begin
      tick();
      n++;
    end
    checkOutput("wait_idle", int'(ifc.busy), 0);
  endtask

  task automatic waitQ(input int val);
    int n = 0;
    while (int'(bankQ) != val && n < 40) begin
      tick();
      n++;
    end
    checkOutput("reach_q", int'(bankQ), val);
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int dir;
    int lim;
    reset = 1'b1;
    ifc.start = 1'b0;
    ifc.stop = 1'b0;
    ifc.up_dn = 1'b0;
    ifc.limit = '0;
    bankLoad = 1'b1;
    bankLoadVal = 4'b0110;
    tick();
    tick();
    bankLoad = 1'b0;
    checkOutput("reset_busy", int'(ifc.busy), 0);
    checkOutput("reset_done", int'(ifc.done), 0);
    checkOutput("reset_tc", int'(ifc.tc), 0);
    checkOutput("reset_t_out", int'(ifc.t_out), 0);
    reset = 1'b0;
    tick();
    checkOutput("idle_t_out", int'(ifc.t_out), 0);

`ifdef TFFC_WRAP_EN
    // Wrapping count to 3: three tc pulses, each with the bank back at 0 and done low.
    pushExp(0, 0, -1);
    pushExp(0, 0, -1);
    pushExp(0, 0, -1);
    applyStimulus(1, 3, 0, 0);
    for (int k = 1; k <= 13; k++) begin
      tick();
      checkOutput("wrap_q", int'(bankQ), (k - 1) % 4);
      checkOutput("wrap_done", int'(ifc.done), 0);
    end
    ifc.stop = 1'b1;
    tick();
    tick();
    ifc.stop = 1'b0;
    checkOutput("wrap_stop_idle", int'(ifc.busy), 0);
`else
    // Start and stop together in IDLE must not launch.
    ifc.start = 1'b1;
    ifc.stop = 1'b1;
    tick();
    tick();
    checkOutput("start_stop_idle", int'(ifc.busy), 0);
    ifc.start = 1'b0;
    ifc.stop = 1'b0;

    // Up count to 5 from a dirty bank.
    loadBank(4'b1010);
    applyStimulus(1, 5, 1, runLatency(1, 5));
    checkOutput("clear_t_out", int'(ifc.t_out), 4'b1010);
    for (int k = 0; k <= 5; k++) begin
      tick();
      checkOutput("up_q", int'(bankQ), k);
    end
    waitIdle();

    // Down count to 12.
    applyStimulus(0, 12, 1, runLatency(0, 12));
    for (int k = 0; k <= 3; k++) begin
      tick();
      checkOutput("down_q", int'(bankQ), 15 - k);
    end
    waitIdle();

    // Limits equal to the post-clear value: zero toggle steps.
    applyStimulus(1, 0, 1, runLatency(1, 0));
    waitIdle();
    applyStimulus(0, 15, 1, runLatency(0, 15));
    waitIdle();

    // Pause at 3, hold, resume to 4, then finish at 9.
    applyStimulus(1, 9, 1, -1);
    tick();
    waitQ(3);
    ifc.stop = 1'b1;
    tick();
    ifc.stop = 1'b0;
    checkOutput("pause_t_out", int'(ifc.t_out), 0);
    tick();
    checkOutput("pause_hold_q", int'(bankQ), 3);
    checkOutput("pause_busy", int'(ifc.busy), 1);
    ifc.start = 1'b1;
    tick();
    ifc.start = 1'b0;
    tick();
    checkOutput("resume_q", int'(bankQ), 4);
    waitIdle();

    // Stop while paused aborts to IDLE without a tc.
    applyStimulus(1, 9, 0, 0);
    tick();
    waitQ(2);
    ifc.stop = 1'b1;
    tick();
    tick();
    ifc.stop = 1'b0;
    checkOutput("abort_idle", int'(ifc.busy), 0);

    // Reset mid-run at q=2.
    applyStimulus(1, 9, 0, 0);
    tick();
    waitQ(2);
    reset = 1'b1;
    tick();
    checkOutput("midrun_reset_busy", int'(ifc.busy), 0);
    checkOutput("midrun_reset_t_out", int'(ifc.t_out), 0);
    checkOutput("midrun_reset_done", int'(ifc.done), 0);
    reset = 1'b0;
    tick();

    // Start held high relaunches right after DONE->IDLE.
    pushExp(1, 1, runLatency(1, 1));
    pushExp(1, 1, runLatency(1, 1));
    ifc.up_dn = 1'b1;
    ifc.limit = 4'd1;
    ifc.start = 1'b1;
    tick();
    begin
      int n = 0;
      while (ifc.busy && n < 20) begin
        tick();
        n++;
      end
    end
    checkOutput("relaunch_idle_gap", int'(ifc.busy), 0);
    tick();
    checkOutput("relaunch_busy", int'(ifc.busy), 1);
    ifc.start = 1'b0;
    waitIdle();

    // Randomized launches from random bank contents.
    for (int r = 0; r < 16; r++) begin
      dir = int'($urandom_range(0, 1));
      lim = int'($urandom_range(0, 15));
      loadBank(int'($urandom_range(0, 15)));
      applyStimulus(dir, lim, 1, runLatency(dir, lim));
      waitIdle();
      tick();
    end
`endif

    tick();
    tick();
    checkOutput("sb_drain", sbQ.size(), 0);
    $display("%0d/%0d checks passed", passCnt, checkCnt);
    $finish;
  end

endmodule
